// File: rtl/network_seq.sv
// rtl/network_seq.sv - time-multiplexed fixed-point network, M layers of N neurons on one shared MAC
// Define NETWORK_SEQ_RELU_EN for ReLU on hidden layers; the last layer is always linear.
module network_seq #(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*W-1:0]       x,
    input  logic [M*N*N*W-1:0]   w,
    input  logic [M*N*W-1:0]     b,
    output logic [N*W-1:0]       y,
    output logic                 busy,
    output logic                 done
);
    localparam int NW = $clog2(N);
    localparam int LW = (M > 1) ? $clog2(M) : 1;
    localparam int AW = 2*W + $clog2(N);
    localparam logic [NW-1:0] LAST_K = NW'(N-1);
    localparam logic [LW-1:0] LAST_L = LW'(M-1);

    typedef enum logic [1:0] {IDLE, MAC, FIN, DONE} state_t;

    state_t                state;
    logic [NW-1:0]         j, k;
    logic [LW-1:0]         l;
    logic                  cur;
    logic [N*W-1:0]        act [2];
    logic signed [AW-1:0]  acc;

    logic [W-1:0]          w_sel, a_sel, b_sel;
    logic signed [2*W-1:0] w_ext, a_ext, prod;
    logic signed [AW-1:0]  acc_sh;
    logic signed [AW:0]    sum;
    logic [W-1:0]          r;
    logic [N*W-1:0]        nxt;

    always_comb begin
        w_sel  = w[((int'(l)*N + int'(j))*N + int'(k))*W +: W];
        a_sel  = act[cur][int'(k)*W +: W];
        b_sel  = b[(int'(l)*N + int'(j))*W +: W];
        w_ext  = {{W{w_sel[W-1]}}, w_sel};
        a_ext  = {{W{a_sel[W-1]}}, a_sel};
        prod   = w_ext * a_ext;
        acc_sh = acc >>> FRAC;
        // one guard bit above the shifted accumulator so the bias add cannot wrap before saturation
        sum    = {acc_sh[AW-1], acc_sh} + {{(AW+1-W){b_sel[W-1]}}, b_sel};
        if (sum[AW:W-1] == '0 || sum[AW:W-1] == '1)
            r = sum[W-1:0];
        else if (sum[AW])
            r = {1'b1, {(W-1){1'b0}}};
        else
            r = {1'b0, {(W-1){1'b1}}};
`ifdef NETWORK_SEQ_RELU_EN
        if (l != LAST_L && r[W-1])
            r = '0;
`else
`endif
        nxt = act[~cur];
        nxt[int'(j)*W +: W] = r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            y      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            act[0] <= '0;
            act[1] <= '0;
            acc    <= '0;
            l      <= '0;
            j      <= '0;
            k      <= '0;
            cur    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        act[0] <= x;
                        cur    <= 1'b0;
                        l      <= '0;
                        j      <= '0;
                        k      <= '0;
                        acc    <= '0;
                        busy   <= 1'b1;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + {{(AW-2*W){prod[2*W-1]}}, prod};
                    if (k == LAST_K) begin
                        k     <= '0;
                        state <= FIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                FIN: begin
                    act[~cur] <= nxt;
                    acc       <= '0;
                    k         <= '0;
                    if (j != LAST_K) begin
                        j     <= j + 1'b1;
                        state <= MAC;
                    end else if (l != LAST_L) begin
                        cur   <= ~cur;
                        l     <= l + 1'b1;
                        j     <= '0;
                        state <= MAC;
                    end else begin
                        y     <= nxt;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_network_seq.sv
// tb_network_seq.sv - directed-vector bench for network_seq at default parameters
// Expectations for activation cases follow NETWORK_SEQ_RELU_EN when it is defined.
module tb_network_seq;
    localparam int N    = 4;
    localparam int M    = 4;
    localparam int W    = 16;
    localparam int FRAC = 8;

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic                start = 1'b0;
    logic [N*W-1:0]      x     = '0;
    logic [M*N*N*W-1:0]  w     = '0;
    logic [M*N*W-1:0]    b     = '0;
    logic [N*W-1:0]      y;
    logic                busy;
    logic                done;

    int n_checks = 0;
    int n_fail   = 0;

    network_seq #(.N(N), .M(M), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .w(w), .b(b),
        .y(y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] vec(input logic [15:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [63:0] fill(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    task automatic set_w(input int li, input int ji, input int ki, input logic [15:0] v);
        w[((li*N + ji)*N + ki)*W +: W] = v;
    endtask

    task automatic set_diag(input logic [15:0] v);
        w = '0;
        for (int li = 0; li < M; li++)
            for (int ji = 0; ji < N; ji++)
                set_w(li, ji, ji, v);
    endtask

    // pulse start, then follow busy/done until done or a cycle budget runs out
    task automatic run(input string tag, input logic [63:0] exp_y);
        int cyc;
        int busy_low;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        busy_low = 0;
        while (!done && cyc < 200) begin
            if (!busy) busy_low++;
            @(negedge clk);
            cyc++;
        end
        expect_eq({tag, "_latency"}, 64'(cyc), 64'd81);
        expect_eq({tag, "_busy_run"}, 64'(busy_low), 64'd0);
        expect_eq({tag, "_busy_done"}, 64'(busy), 64'd1);
        expect_eq({tag, "_y"}, y, exp_y);
        @(negedge clk);
        expect_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
        expect_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    logic [63:0] xi;
    logic [63:0] exp_neg;
    logic [63:0] exp_act;
    int done_cnt;
    int d1, d2;
    logic busy82;

    initial begin
        xi = vec(16'h0100, 16'h0200, 16'h0300, 16'h0400);
`ifdef NETWORK_SEQ_RELU_EN
        exp_neg = '0;
        exp_act = '0;
`else
        exp_neg = fill(16'h8000);
        exp_act = xi;
`endif
        repeat (3) @(negedge clk);
        expect_eq("reset_y", y, 64'd0);
        expect_eq("reset_busy", 64'(busy), 64'd0);
        expect_eq("reset_done", 64'(done), 64'd0);
        rst = 1'b0;

        set_diag(16'h0100); b = '0; x = xi;
        run("identity", xi);

        set_diag(16'h7FFF); x = fill(16'h7FFF);
        run("sat_pos", fill(16'h7FFF));
        x = fill(16'h8000);
        run("sat_neg", exp_neg);

        set_diag(16'hFF00); x = xi;
        run("neg_identity", exp_act);

        w = '0; b = {16{16'h0080}};
        run("bias_only", fill(16'h0080));

        set_diag(16'h0001); b = '0; x = fill(16'h0001);
        run("floor_pos", 64'd0);
        x = fill(16'hFFFF);
`ifdef NETWORK_SEQ_RELU_EN
        run("floor_neg", 64'd0);
`else
        run("floor_neg", fill(16'hFFFF));
`endif

        // layer 0 rotates, layer 1 row 0 sums, bias only on layer 3
        set_diag(16'h0100);
        for (int ji = 0; ji < N; ji++) begin
            set_w(0, ji, ji, 16'h0000);
            set_w(0, ji, (ji + 1) % N, 16'h0100);
            set_w(1, 0, ji, 16'h0100);
            b[(3*N + ji)*W +: W] = 16'(16'h0010 * ji);
        end
        x = xi;
        run("mixed", vec(16'h0A00, 16'h0310, 16'h0420, 16'h0130));

        set_diag(16'h0100); b = '0; x = xi;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        done_cnt = 0; d1 = 0;
        for (int cyc = 1; cyc <= 180; cyc++) begin
            start = (cyc == 10 || cyc == 81);
            if (done) begin
                done_cnt++;
                d1 = cyc;
            end
            @(negedge clk);
        end
        start = 1'b0;
        expect_eq("repulse_done_count", 64'(done_cnt), 64'd1);
        expect_eq("repulse_done_cycle", 64'(d1), 64'd81);
        expect_eq("repulse_y", y, xi);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        d1 = 0; d2 = 0; busy82 = 1'b1;
        for (int cyc = 1; cyc <= 260; cyc++) begin
            if (cyc == 200) start = 1'b0;
            if (done) begin
                if (d1 == 0) d1 = cyc;
                else if (d2 == 0) d2 = cyc;
            end
            if (cyc == 82) busy82 = busy;
            @(negedge clk);
        end
        expect_eq("b2b_first_done", 64'(d1), 64'd81);
        expect_eq("b2b_second_done", 64'(d2), 64'd163);
        expect_eq("b2b_busy_gap", 64'(busy82), 64'd0);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 40; cyc++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_eq("midrst_busy", 64'(busy), 64'd0);
        expect_eq("midrst_y", y, 64'd0);
        done_cnt = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        expect_eq("midrst_no_done", 64'(done_cnt), 64'd0);
        run("after_reset", xi);

        @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        expect_eq("rst_wins_busy", 64'(busy), 64'd0);
        expect_eq("rst_wins_y", y, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
